bram_fifo_ctrl: RTL and testbench

BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

---
 rtl/bram_fifo_pkg.sv | 17 +
 rtl/bram_fifo_ctrl_out_skid_buf.sv | 66 ++++++
 rtl/bram_fifo_ctrl.sv | 94 +++++++++
 tb/tb_bram_fifo_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared defaults and width derivations for the block-RAM backed FIFO controller.
package bram_fifo_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultDepth = 1024;

  // Pointer carries one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Count must reach DEPTH plus the two output-buffer entries.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/bram_fifo_ctrl_out_skid_buf.sv
// Two-entry output buffer fed by RAM read data; entry 0 always holds the oldest word.
module out_skid_buf
  import bram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       entries
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             pop_ok;

  assign pop_ok = pop && (cnt_q != 2'd0);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    unique case ({push, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_data;
        else               ent1_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid   = (cnt_q != 2'd0);
  assign data    = ent0_q;
  assign entries = cnt_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller around an external dual-port block RAM with a 2-entry prefetch buffer
// so the read side sees one word per clock despite the RAM's one-cycle read latency.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [$clog2(DEPTH)+1:0] count,
  output logic                     ram_we_a,
  output logic [$clog2(DEPTH)-1:0] ram_addr_a,
  output logic [WIDTH-1:0]         ram_din_a,
  output logic                     ram_re_b,
  output logic [$clog2(DEPTH)-1:0] ram_addr_b,
  input  logic [WIDTH-1:0]         ram_dout_b
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = ptr_width(DEPTH);
  localparam int unsigned CntW  = cnt_width(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            inflight_q;
  logic            armed_q;
  logic [PtrW-1:0] occ;
  logic            ram_full;
  logic            pop;
  logic [1:0]      buf_entries;
  logic [1:0]      pend;

  assign occ      = wr_ptr_q - rd_ptr_q;
  assign ram_full = (occ == PtrW'(DEPTH));

  // armed_q holds s_ready low through reset and sets on the first edge after release.
  assign s_ready  = armed_q && !ram_full;
  assign ram_we_a = s_valid && s_ready;
  assign ram_din_a  = s_data;
  assign ram_addr_a = wr_ptr_q[AddrW-1:0];

  assign pop  = m_valid && m_ready;
  assign pend = buf_entries + {1'b0, inflight_q};

  // Prefetch while buffered plus in-flight words stay below two, or exactly two with a pop.
  assign ram_re_b   = (occ != '0) && ((pend < 2'd2) || ((pend == 2'd2) && pop));
  assign ram_addr_b = rd_ptr_q[AddrW-1:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(ram_we_a);
    rd_ptr_d = rd_ptr_q + PtrW'(ram_re_b);
    count_d  = count_q + CntW'(ram_we_a) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= ram_re_b;
      armed_q    <= 1'b1;
    end
  end

  assign count = count_q;

  out_skid_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (ram_dout_b),
    .pop       (pop),
    .valid     (m_valid),
    .data      (m_data),
    .entries   (buf_entries)
  );

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Randomised bench for bram_fifo_ctrl with a queue-based reference model and a RAM model.
module tb_bram_fifo_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid, s_ready, m_valid, m_ready;
  logic [WIDTH-1:0] s_data, m_data;
  logic [CW-1:0]    count;
  logic             ram_we_a, ram_re_b;
  logic [AW-1:0]    ram_addr_a, ram_addr_b;
  logic [WIDTH-1:0] ram_din_a, ram_dout_b;

  always #5 clk = ~clk;

  bram_fifo_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .count      (count),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_re_b   (ram_re_b),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b)
  );

  // Dual-port RAM: registered read, contents untouched by reset.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_re_b) ram_dout_b <= mem[ram_addr_b];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words held in order with the edge index at which each was accepted.
  logic [WIDTH-1:0] exp_q[$];
  int unsigned      edge_q[$];
  int unsigned      cyc = 0;
  bit               pushed_now = 0;
  bit               ready_armed = 0;
  bit               fire_push = 0, fire_pop = 0;
  logic [WIDTH-1:0] push_word;

  logic [WIDTH-1:0] pop_log[$];
  int unsigned      pop_cyc[$];
  bit               seen_valid = 0;
  int unsigned      first_valid_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      edge_q.delete();
      pushed_now  = 0;
      ready_armed = 0;
    end else begin
      cyc++;
      if (fire_pop) begin
        void'(exp_q.pop_front());
        void'(edge_q.pop_front());
      end
      if (fire_push) begin
        exp_q.push_back(push_word);
        edge_q.push_back(cyc);
      end
      pushed_now  = fire_push;
      ready_armed = 1;
    end
  end

  // A word reaches the output two edges after acceptance; up to two eligible words sit
  // outside the RAM, so RAM occupancy is what remains.
  always @(negedge clk) begin : cmp
    int unsigned size, elig, pf, occ;
    logic        exp_ready, exp_valid;
    size = exp_q.size();
    if (!rst_n) begin
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_count", count, 0);
      check("rst_we", ram_we_a, 0);
      check("rst_re", ram_re_b, 0);
      fire_push = 0;
      fire_pop  = 0;
    end else begin
      elig      = size - (pushed_now ? 1 : 0);
      pf        = (elig < 2) ? elig : 2;
      occ       = size - pf;
      exp_ready = ready_armed && (occ != DEPTH);
      exp_valid = (size != 0) && (edge_q[0] + 2 <= cyc);
      check("s_ready", s_ready, exp_ready);
      check("m_valid", m_valid, exp_valid);
      check("count", count, size);
      check("count_max", count <= CW'(DEPTH + 2), 1);
      check("we_a", ram_we_a, s_valid && exp_ready);
      if (ram_we_a && ram_re_b) check("addr_clash", ram_addr_a != ram_addr_b, 1);
      if (m_valid && exp_valid) check("m_data", m_data, exp_q[0]);
      fire_push = s_valid && s_ready;
      fire_pop  = m_valid && m_ready;
      push_word = s_data;
      if (fire_pop) begin
        pop_log.push_back(m_data);
        pop_cyc.push_back(cyc);
      end
      if (m_valid && !seen_valid) begin
        seen_valid      = 1;
        first_valid_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_log.delete();
    pop_cyc.delete();
    seen_valid = 0;
  endtask

  task automatic drain();
    int guard;
    guard   = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while ((count != 0 || m_valid) && guard < 200) begin
      step();
      guard++;
    end
    check("drain_empty", count, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int unsigned accepted, stalls, pushed, guard, first_push, rp;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_count", count, 0);
    check("init_s_ready", s_ready, 0);
    rst_n = 1'b1;
    step();
    check("ready_after_reset", s_ready, 1);

    // Five words with the consumer always ready.
    clear_logs();
    m_ready    = 1'b1;
    first_push = 0;
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1;
      s_data  = WIDTH'(i);
      step();
      if (i == 1) first_push = cyc;
    end
    s_valid = 1'b0;
    guard   = 0;
    while (pop_log.size() < 5 && guard < 20) begin
      step();
      guard++;
    end
    check("t1_pops", pop_log.size(), 5);
    for (int i = 0; i < 5; i++) check("t1_data", pop_log[i], i + 1);
    check("t1_latency", first_valid_cyc - first_push, 2);
    drain();

    // Fill with the consumer stalled.
    m_ready  = 1'b0;
    accepted = 0;
    guard    = 0;
    while (guard < 4 * DEPTH) begin
      s_valid = 1'b1;
      s_data  = WIDTH'($urandom);
      if (s_ready) accepted++;
      step();
      guard++;
      if (!s_ready) break;
    end
    s_valid = 1'b0;
    check("t2_accepted", accepted, 18);
    check("t2_full_count", count, 18);
    check("t2_full_ready", s_ready, 0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("t2_ready_after_pop", s_ready, 1);
    check("t2_count_after_pop", count, 17);
    drain();

    // Continuous streaming across several pointer wraps.
    clear_logs();
    m_ready = 1'b1;
    stalls  = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      s_valid = 1'b1;
      s_data  = WIDTH'($urandom);
      if (!s_ready) stalls++;
      step();
    end
    s_valid = 1'b0;
    guard   = 0;
    while (pop_log.size() < 3 * DEPTH && guard < 100) begin
      step();
      guard++;
    end
    check("t3_stalls", stalls, 0);
    check("t3_pops", pop_log.size(), 3 * DEPTH);
    check("t3_no_gaps", pop_cyc[pop_log.size() - 1] - pop_cyc[0], 3 * DEPTH - 1);
    drain();

    // Random traffic with phased backpressure.
    pushed = 0;
    guard  = 0;
    while (pushed < 10000 && guard < 60000) begin
      rp      = 20 + 20 * ((pushed / 1000) % 4);
      s_valid = ($urandom_range(0, 99) < 75);
      s_data  = WIDTH'($urandom);
      m_ready = ($urandom_range(0, 99) < rp);
      if (s_valid && s_ready) pushed++;
      step();
      guard++;
    end
    check("t4_words", pushed, 10000);
    drain();

    // Reset with words held, then a fresh word must come out first.
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = WIDTH'(16'h7000 + i);
      step();
    end
    s_valid = 1'b0;
    step();
    step();
    check("t5_held", count, 7);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_count", count, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    clear_logs();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'hABCD;
    step();
    s_valid = 1'b0;
    guard   = 0;
    while (pop_log.size() < 1 && guard < 10) begin
      step();
      guard++;
    end
    check("t5_pops", pop_log.size(), 1);
    check("t5_first_word", pop_log[0], 16'hABCD);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
